ws2812b_chain_driver: RTL and testbench
=======================================

WS2812B_CHAIN_DRIVER -- requirements
Module: ws2812b_chain_driver

Interface
REQ-001 Parameter LED_NUM, default 8: number of LEDs in the chain, range 1..1024.
REQ-002 Parameter T_BIT, default 34: clock cycles per data bit (1.25 us at 27 MHz).
REQ-003 Parameter T0H, default 11: high cycles for a '0' bit; T1H, default 22: high cycles for a '1' bit.
REQ-004 Parameter T_RST, default 8100: low cycles of the latch gap (300 us at 27 MHz).
REQ-005 Parameter T_HOLD, default 13_500_000: cycles between frame starts in the animated modes (0.5 s).
REQ-006 Clock  input  1  system clock; the only clock.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  level enable; while high, frames are generated continuously.
REQ-009 mode  input  2  0 = static colour, 1 = colour cycle, 2 = chase, 3 = off (all zero).
REQ-010 color_in  input  24  {G,R,B} colour used by modes 0 and 2; sampled at frame start only.
REQ-011 busy  output  1  high from frame start until the latch gap has finished.
REQ-012 frame_done  output  1  one-cycle pulse on the last cycle of the latch gap.
REQ-013 WS2812B_IO  output  1  serial data line to the first LED.

Function
REQ-014 FSM states are IDLE, LOAD, SEND, LATCH and HOLD.
REQ-015 IDLE -> LOAD when en=1; LOAD latches mode, color_in and frame_cnt into a frame snapshot and lasts exactly one cycle.
REQ-016 SEND transmits LED_NUM x 24 bits, MSB first, in order G7..G0, R7..R0, B7..B0; LED index 0 is sent first.
REQ-017 Each bit lasts exactly T_BIT cycles: WS2812B_IO is high for T0H or T1H cycles, then low for the rest of the bit.
REQ-018 Bits are contiguous, with no idle cycle between bits or LEDs; a frame therefore lasts exactly LED_NUM*24*T_BIT cycles in SEND.
REQ-019 LATCH holds WS2812B_IO low for exactly T_RST cycles; frame_done pulses on the final LATCH cycle.
REQ-020 After LATCH: modes 0 and 3 go to LOAD if en=1, else IDLE; modes 1 and 2 go to HOLD.
REQ-021 HOLD waits until T_HOLD cycles have elapsed since LOAD, then goes to LOAD if en=1, else IDLE. If the frame is longer than T_HOLD, HOLD lasts 1 cycle.
REQ-022 Mode 1 colour per frame, all LEDs identical, sequence white, blue, green, red, off, then repeat: {FF,FF,FF}, {00,00,FF}, {FF,00,00}, {00,FF,00}, {00,00,00} in GRB order.
REQ-023 Mode 2: LED index (frame_cnt mod LED_NUM) shows the snapshot colour; all other LEDs show zero.
REQ-024 frame_cnt increments by 1 at each LATCH exit. It wraps at 5 in mode 1 and at LED_NUM in mode 2, and is cleared when the snapshot mode differs from the previous frame's mode.
REQ-025 en falling mid-frame does not truncate the frame: SEND and LATCH always complete. Changes to mode or color_in mid-frame take effect at the next LOAD only.
REQ-026 busy = 1 in LOAD, SEND and LATCH; busy = 0 in IDLE and HOLD.
REQ-027 Counter widths are derived with $clog2 of their maximum value; no counter overflows at the maximum parameter values.

Reset
REQ-028 rst=0 asynchronously forces IDLE, WS2812B_IO=0, busy=0, frame_done=0, frame_cnt=0, all timers 0 and the snapshot to zero.
REQ-029 Reset asserted mid-frame aborts the frame immediately; after release the next frame starts from LED 0, bit 23.
REQ-030 No initial blocks are used; reset is the only initialisation.

Structure
REQ-031 The shared package ws2812b_pkg holds the mode encodings, the FSM state enum and the mode-1 colour table.
REQ-032 The single sub-module ws2812b_bit_tx takes a bit plus a start strobe, returns a done strobe, and generates the T0H/T1H/T_BIT waveform; the top level holds the FSM, pixel/bit counters and colour selection.
REQ-033 The design contains no derived clocks and no edge-sensitive logic on data signals; every register is clocked on posedge Clock.

Verification (LED_NUM=4, T_BIT=34, T0H=11, T1H=22, T_RST=100, T_HOLD=5000)
REQ-034 Mode 0, color_in=24'hFF0000, en=1 -> the decoded stream is 4 x {FF,00,00}; SEND lasts 3264 cycles, then 100 low cycles; frame_done pulses once.
REQ-035 Mode 1, en held high for 6 frames -> colours in order white, blue, green, red, off, white; frame starts are exactly 5000 cycles apart.
REQ-036 Mode 2, color_in=24'h00FF00, 5 frames -> the lit LED index is 0, 1, 2, 3, 0.
REQ-037 en dropped during bit 40 of frame 1 -> frame completes, busy falls after LATCH, FSM reaches IDLE and no further edges appear on WS2812B_IO.
REQ-038 rst pulsed low during SEND -> WS2812B_IO=0 and busy=0 in the same cycle; after release the first bit decoded is bit 23 of LED 0.
REQ-039 Bit timing checker -> every high pulse is exactly 11 or 22 cycles, every bit period is 34 cycles, and every gap between frames is at least 100 cycles.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B chain driver: mode encodings,
// controller state encoding and the colour-cycle table.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_CYCLE  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // Number of entries in the colour-cycle sequence.
  localparam int CYCLE_LEN = 5;

  // Index of the first transmitted bit of a pixel (G7).
  localparam logic [4:0] BIT_MSB = 5'd23;

  // Colour-cycle sequence in {G,R,B} order: white, blue, green, red, off.
  function automatic logic [23:0] cycle_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFF_FF_FF;
      3'd1:    c = 24'h00_00_FF;
      3'd2:    c = 24'hFF_00_00;
      3'd3:    c = 24'h00_FF_00;
      3'd4:    c = 24'h00_00_00;
      default: c = 24'h00_00_00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ws2812b_bit_tx.sv
// Single-bit WS2812B waveform generator. A start strobe loads one data bit;
// the line is driven high for T0H or T1H cycles and low for the rest of a
// T_BIT-cycle slot. done is high on the final cycle of the slot, so a start
// issued in that same cycle yields back-to-back bits with no idle cycle.
module ws2812b_bit_tx #(
  parameter int T_BIT = 34,
  parameter int T0H   = 11,
  parameter int T1H   = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_in,
  output logic done,
  output logic tx_out
);

  // Wide enough to hold T_BIT itself so T1H up to T_BIT is representable.
  localparam int CNT_W = $clog2(T_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] HIGH_0   = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HIGH_1   = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             active_q, active_d;
  logic             io_q, io_d;
  logic             done_q, done_d;

  // Next-state for the slot counter, high-time latch and registered outputs.
  always_comb begin
    cnt_d    = cnt_q;
    high_d   = high_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = {CNT_W{1'b0}};
      active_d = 1'b1;
      high_d   = bit_in ? HIGH_1 : HIGH_0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d    = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    // Output and done are registered from next-state so they line up with cnt_q.
    io_d   = active_d && (cnt_d < high_d);
    done_d = active_d && (cnt_d == CNT_LAST);
  end

  // Register slot state and outputs; reset forces the line low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      high_q   <= {CNT_W{1'b0}};
      active_q <= 1'b0;
      io_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      active_q <= active_d;
      io_q     <= io_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign tx_out = io_q;

endmodule

// File: rtl/ws2812b_chain_driver.sv
// WS2812B LED chain driver. Generates complete frames (pixels, latch gap and
// optional hold time) for static, colour-cycle, chase and off patterns.
// The frame parameters are snapshotted at frame start so input changes only
// take effect on the next frame.
module ws2812b_chain_driver
  import ws2812b_pkg::*;
#(
  parameter int LED_NUM = 8,
  parameter int T_BIT   = 34,
  parameter int T0H     = 11,
  parameter int T1H     = 22,
  parameter int T_RST   = 8100,
  parameter int T_HOLD  = 13_500_000
) (
  input  logic        Clock,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] color_in,
  output logic        busy,
  output logic        frame_done,
  output logic        WS2812B_IO
);

  localparam int LED_W    = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int FCNT_MAX = (LED_NUM > CYCLE_LEN) ? LED_NUM : CYCLE_LEN;
  localparam int FCNT_W   = $clog2(FCNT_MAX);
  localparam int LATCH_W  = (T_RST > 1) ? $clog2(T_RST) : 1;
  localparam int HOLD_W   = $clog2(T_HOLD + 1);

  localparam logic [LED_W-1:0]   LED_LAST   = LED_W'(LED_NUM - 1);
  localparam logic [LED_W-1:0]   LED_ONE    = LED_W'(1);
  localparam logic [FCNT_W-1:0]  CHASE_LAST = FCNT_W'(LED_NUM - 1);
  localparam logic [FCNT_W-1:0]  CYCLE_LAST = FCNT_W'(CYCLE_LEN - 1);
  localparam logic [FCNT_W-1:0]  FCNT_ONE   = FCNT_W'(1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(T_RST - 1);
  localparam logic [LATCH_W-1:0] LATCH_ONE  = LATCH_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_EXIT  = HOLD_W'(T_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_SAT   = HOLD_W'(T_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  state_e              state_q, state_d;
  mode_e               snap_mode_q, snap_mode_d;
  logic [23:0]         snap_color_q, snap_color_d;
  logic [FCNT_W-1:0]   snap_fcnt_q, snap_fcnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [4:0]          bit_q, bit_d;
  logic [LATCH_W-1:0]  latch_q, latch_d;
  logic [HOLD_W-1:0]   since_q, since_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tx_start_s;
  logic                tx_bit_s;
  logic                tx_done_s;
  logic                tx_io_s;
  logic [23:0]         pix_s;

  // Colour of one LED for a given frame snapshot.
  function automatic logic [23:0] pixel_color(
    input mode_e             m,
    input logic [23:0]       c,
    input logic [FCNT_W-1:0] fc,
    input logic [LED_W-1:0]  idx
  );
    logic [23:0] p;
    case (m)
      MODE_STATIC: p = c;
      MODE_CYCLE:  p = cycle_color(fc[2:0]);
      MODE_CHASE:  p = (FCNT_W'(idx) == fc) ? c : 24'h00_00_00;
      MODE_OFF:    p = 24'h00_00_00;
      default:     p = 24'h00_00_00;
    endcase
    return p;
  endfunction

  ws2812b_bit_tx #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_tx (
    .clk    (Clock),
    .rst_n  (rst),
    .start  (tx_start_s),
    .bit_in (tx_bit_s),
    .done   (tx_done_s),
    .tx_out (tx_io_s)
  );

  // Frame sequencing: next state, snapshot, pixel/bit position and timers.
  always_comb begin
    state_d      = state_q;
    snap_mode_d  = snap_mode_q;
    snap_color_d = snap_color_q;
    snap_fcnt_d  = snap_fcnt_q;
    frame_cnt_d  = frame_cnt_q;
    led_d        = led_q;
    bit_d        = bit_q;
    latch_d      = latch_q;
    since_d      = (since_q >= HOLD_SAT) ? since_q : since_q + HOLD_ONE;
    tx_start_s   = 1'b0;
    tx_bit_s     = 1'b0;
    pix_s        = 24'h00_00_00;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        snap_mode_d  = mode_e'(mode);
        snap_color_d = color_in;
        // A new pattern always starts from its first step.
        if (mode_e'(mode) != snap_mode_q) begin
          frame_cnt_d = {FCNT_W{1'b0}};
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
        snap_fcnt_d = frame_cnt_d;
        led_d       = {LED_W{1'b0}};
        bit_d       = BIT_MSB;
        since_d     = HOLD_ONE;
        // Kick off LED 0 bit 23 now so SEND is exactly LED_NUM*24*T_BIT long.
        pix_s       = pixel_color(snap_mode_d, snap_color_d, snap_fcnt_d, {LED_W{1'b0}});
        tx_start_s  = 1'b1;
        tx_bit_s    = pix_s[BIT_MSB];
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (tx_done_s) begin
          if ((led_q == LED_LAST) && (bit_q == 5'd0)) begin
            latch_d = {LATCH_W{1'b0}};
            state_d = ST_LATCH;
          end else begin
            if (bit_q == 5'd0) begin
              bit_d = BIT_MSB;
              led_d = led_q + LED_ONE;
            end else begin
              bit_d = bit_q - 5'd1;
              led_d = led_q;
            end
            pix_s      = pixel_color(snap_mode_q, snap_color_q, snap_fcnt_q, led_d);
            tx_start_s = 1'b1;
            tx_bit_s   = pix_s[bit_d];
            state_d    = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_LATCH: begin
        if (latch_q == LATCH_LAST) begin
          if (snap_mode_q == MODE_CYCLE) begin
            frame_cnt_d = (snap_fcnt_q >= CYCLE_LAST) ? {FCNT_W{1'b0}} : snap_fcnt_q + FCNT_ONE;
          end else begin
            frame_cnt_d = (snap_fcnt_q >= CHASE_LAST) ? {FCNT_W{1'b0}} : snap_fcnt_q + FCNT_ONE;
          end
          if ((snap_mode_q == MODE_CYCLE) || (snap_mode_q == MODE_CHASE)) begin
            state_d = ST_HOLD;
          end else if (en) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          latch_d = latch_q + LATCH_ONE;
          state_d = ST_LATCH;
        end
      end

      ST_HOLD: begin
        // Leave so that the next LOAD lands exactly T_HOLD cycles after the last one.
        if (since_q >= HOLD_EXIT) begin
          if (en) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) || (state_d == ST_LATCH);
    done_d = (state_d == ST_LATCH) && (latch_d == LATCH_LAST);
  end

  // Register FSM state, frame snapshot, counters and the status outputs.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      snap_mode_q  <= MODE_STATIC;
      snap_color_q <= 24'h00_00_00;
      snap_fcnt_q  <= {FCNT_W{1'b0}};
      frame_cnt_q  <= {FCNT_W{1'b0}};
      led_q        <= {LED_W{1'b0}};
      bit_q        <= 5'd0;
      latch_q      <= {LATCH_W{1'b0}};
      since_q      <= {HOLD_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_mode_q  <= snap_mode_d;
      snap_color_q <= snap_color_d;
      snap_fcnt_q  <= snap_fcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      led_q        <= led_d;
      bit_q        <= bit_d;
      latch_q      <= latch_d;
      since_q      <= since_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign WS2812B_IO = tx_io_s;

endmodule

// File: tb/tb_ws2812b_chain_driver.sv
// Scoreboard bench for ws2812b_chain_driver: stimulus pushes expected pixel
// colours, a monitor decodes the serial line and checks pixels and timing.
`timescale 1ns/1ps
module tb_ws2812b_chain_driver;

  localparam int LED_NUM = 4;
  localparam int T_BIT   = 34;
  localparam int T0H     = 11;
  localparam int T1H     = 22;
  localparam int T_RST   = 100;
  localparam int T_HOLD  = 5000;
  localparam int SEND_CYC = LED_NUM * 24 * T_BIT;   // 3264

  logic        Clock = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] color_in;
  logic        busy;
  logic        frame_done;
  logic        WS2812B_IO;

  always #5 Clock = ~Clock;

  ws2812b_chain_driver #(
    .LED_NUM (LED_NUM),
    .T_BIT   (T_BIT),
    .T0H     (T0H),
    .T1H     (T1H),
    .T_RST   (T_RST),
    .T_HOLD  (T_HOLD)
  ) dut (
    .Clock      (Clock),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .color_in   (color_in),
    .busy       (busy),
    .frame_done (frame_done),
    .WS2812B_IO (WS2812B_IO)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] cyc_tab [5] = '{24'hFFFFFF, 24'h0000FF, 24'hFF0000, 24'h00FF00, 24'h000000};

  int frames_started = 0;
  int done_cnt       = 0;
  int rise_cnt       = 0;
  int exp_spacing    = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_px(input bit ok, input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%06h required=%06h", name, act, req);
    end
  endtask

  // Expected LED colours of one frame, pushed LED 0 first.
  task automatic push_frame(input int m, input logic [23:0] c, input int fc);
    for (int i = 0; i < LED_NUM; i++) begin
      case (m)
        0:       exp_q.push_back(c);
        1:       exp_q.push_back(cyc_tab[fc % 5]);
        2:       exp_q.push_back((i == (fc % LED_NUM)) ? c : 24'h000000);
        default: exp_q.push_back(24'h000000);
      endcase
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic wait_started(input int target, input int budget, input string name);
    int n = 0;
    do begin
      @(posedge Clock);
      n++;
    end while ((frames_started < target) && (n < budget));
    #2;
    check(frames_started >= target, name, frames_started, target);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    do begin
      @(posedge Clock);
      n++;
    end while ((done_cnt < target) && (n < budget));
    #2;
    check(done_cnt == target, name, done_cnt, target);
  endtask

  task automatic do_reset();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    rst = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
  endtask

  // Monitor: decode the line on the falling clock edge and score it.
  initial begin : monitor
    int cyc = 0;
    int hi_len = 0;
    int low_len = 0;
    int nbits = 0;
    int last_rise = 0;
    int prev_start = 0;
    bit prev_start_valid = 0;
    bit in_frame = 0;
    bit gap_skip = 1;
    bit prev_io = 0;
    bit prev_done = 0;
    logic [23:0] pix = 24'h0;
    logic [23:0] expv;
    logic        b;
    forever begin
      @(negedge Clock);
      cyc++;
      if (!rst) begin
        in_frame = 0; nbits = 0; hi_len = 0; low_len = 0;
        gap_skip = 1; prev_start_valid = 0; prev_io = 0; prev_done = 0;
      end else begin
        if (WS2812B_IO) begin
          if (!prev_io) begin
            rise_cnt++;
            if (!in_frame) begin
              if (!gap_skip) check(low_len >= T_RST, "frame_gap", low_len, T_RST);
              gap_skip = 0;
              if (prev_start_valid && (exp_spacing != 0))
                check(cyc - prev_start == exp_spacing, "frame_spacing", cyc - prev_start, exp_spacing);
              prev_start = cyc;
              prev_start_valid = 1;
              in_frame = 1;
              frames_started++;
            end else begin
              check(cyc - last_rise == T_BIT, "bit_period", cyc - last_rise, T_BIT);
            end
            last_rise = cyc;
            hi_len = 0;
          end
          hi_len++;
        end else begin
          if (prev_io) begin
            b = (hi_len == T1H);
            check((hi_len == T0H) || (hi_len == T1H), "high_pulse", hi_len, b ? T1H : T0H);
            pix = {pix[22:0], b};
            nbits++;
            if (nbits == 24) begin
              nbits = 0;
              if (exp_q.size() == 0) begin
                check_px(1'b0, "unexpected_pixel", pix, 24'h000000);
              end else begin
                expv = exp_q.pop_front();
                check_px(pix == expv, "pixel", pix, expv);
              end
            end
            low_len = 0;
          end
          low_len++;
          if (in_frame && (low_len > T_BIT)) begin
            in_frame = 0;
            check(nbits == 0, "partial_pixel", nbits, 0);
            nbits = 0;
          end
        end
        if (frame_done) begin
          check(!prev_done, "done_width", 2, 1);
          check(busy == 1'b1, "done_busy", busy, 1);
          if (prev_start_valid)
            check(cyc - prev_start == SEND_CYC + T_RST - 1, "frame_length",
                  cyc - prev_start, SEND_CYC + T_RST - 1);
          done_cnt++;
        end
        prev_io = WS2812B_IO;
        prev_done = frame_done;
      end
    end
  end

  // Stimulus: directed scenarios, each pushing its expected pixels first.
  initial begin : stimulus
    int base_s;
    int base_d;
    int r;
    rst = 1'b0; en = 1'b0; mode = 2'd0; color_in = 24'h000000;
    wait_cycles(3);
    check(WS2812B_IO == 1'b0, "reset_io", WS2812B_IO, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(frame_done == 1'b0, "reset_done", frame_done, 0);
    rst = 1'b1;
    wait_cycles(5);
    check(busy == 1'b0, "idle_busy", busy, 0);

    // Static red, two back-to-back frames.
    mode = 2'd0; color_in = 24'hFF0000; exp_spacing = 1 + SEND_CYC + T_RST;
    push_frame(0, 24'hFF0000, 0);
    push_frame(0, 24'hFF0000, 0);
    base_s = frames_started; base_d = done_cnt;
    en = 1'b1;
    wait_started(base_s + 2, 8000, "static_start");
    en = 1'b0;
    wait_done(base_d + 2, 8000, "static_done");
    wait_cycles(3);
    check(busy == 1'b0, "static_idle", busy, 0);

    // en dropped during bit 40: frame completes, then the line stays quiet.
    do_reset();
    mode = 2'd0; color_in = 24'h0FA53C; exp_spacing = 0;
    push_frame(0, 24'h0FA53C, 0);
    base_s = frames_started; base_d = done_cnt;
    en = 1'b1;
    wait_started(base_s + 1, 500, "endrop_start");
    wait_cycles(40 * T_BIT + 15);
    en = 1'b0;
    check(busy == 1'b1, "endrop_busy_mid", busy, 1);
    wait_done(base_d + 1, 4000, "endrop_done");
    wait_cycles(2);
    check(busy == 1'b0, "endrop_busy_low", busy, 0);
    r = rise_cnt;
    wait_cycles(400);
    check(rise_cnt == r, "endrop_no_edges", rise_cnt, r);
    check(done_cnt == base_d + 1, "endrop_no_frame", done_cnt, base_d + 1);

    // Colour cycle for six frames, then chase for five (mode change mid-frame).
    do_reset();
    mode = 2'd1; color_in = 24'h123456; exp_spacing = T_HOLD;
    for (int f = 0; f < 6; f++) push_frame(1, 24'h000000, f);
    base_s = frames_started; base_d = done_cnt;
    en = 1'b1;
    wait_started(base_s + 6, 6 * T_HOLD, "cycle_start");
    mode = 2'd2; color_in = 24'h00FF00;
    for (int f = 0; f < 5; f++) push_frame(2, 24'h00FF00, f);
    wait_started(base_s + 11, 6 * T_HOLD, "chase_start");
    en = 1'b0;
    wait_done(base_d + 11, 6000, "chase_done");
    wait_cycles(2);
    check(busy == 1'b0, "chase_hold_busy", busy, 0);

    // Reset mid-frame: line and busy drop at once, next frame restarts cleanly.
    do_reset();
    mode = 2'd0; color_in = 24'h80013C; exp_spacing = 0;
    push_frame(0, 24'h80013C, 0);
    base_s = frames_started;
    en = 1'b1;
    wait_started(base_s + 1, 500, "abort_start");
    wait_cycles(1000);
    rst = 1'b0;
    #1;
    check(WS2812B_IO == 1'b0, "abort_io", WS2812B_IO, 0);
    check(busy == 1'b0, "abort_busy", busy, 0);
    exp_q.delete();
    wait_cycles(3);
    push_frame(0, 24'h80013C, 0);
    base_s = frames_started; base_d = done_cnt;
    rst = 1'b1;
    wait_started(base_s + 1, 500, "restart_start");
    en = 1'b0;
    wait_done(base_d + 1, 4000, "restart_done");
    wait_cycles(3);
    check(exp_q.size() == 0, "final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
